// File: rtl/nf10_axis_width_converter_v2_if.sv
// AXI4-Stream bundle used on both sides of the width converter.
// The master modport drives a stream and the slave modport receives one.
interface nf10_axis_width_converter_v2_if #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 128
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [USER_WIDTH-1:0]   tuser;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (output tdata, output tstrb, output tuser, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tstrb, input tuser, input tvalid, input tlast, output tready);
endinterface

// File: rtl/nf10_axis_width_converter_v2.sv
// AXI4-Stream width converter. It upsizes, downsizes or passes through depending on the two widths.
// It keeps the first-beat TUSER for the whole packet and reports the byte length of each accepted packet.
module nf10_axis_width_converter_v2 #(
    parameter int C_M_AXIS_DATA_WIDTH = 64,
    parameter int C_S_AXIS_DATA_WIDTH = 256,
    parameter int C_USER_WIDTH        = 128,
    parameter int C_LEN_WIDTH         = 16
) (
    input  logic                   axi_aclk,
    input  logic                   axi_reset,
    nf10_axis_width_converter_v2_if.slave  s_axis,
    nf10_axis_width_converter_v2_if.master m_axis,
    output logic [C_LEN_WIDTH-1:0] pkt_len,
    output logic                   pkt_len_valid
);
    localparam int S_W   = C_S_AXIS_DATA_WIDTH;
    localparam int M_W   = C_M_AXIS_DATA_WIDTH;
    localparam int SB    = S_W / 8;
    localparam int MB    = M_W / 8;
    localparam int RATIO = (M_W >= S_W) ? (M_W / S_W) : (S_W / M_W);
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int BC_W  = $clog2(SB) + 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

    // The beat byte count is the highest set strobe index plus one; strobes are contiguous from lane 0.
    function automatic logic [BC_W-1:0] beat_bytes(input logic [SB-1:0] strb);
        logic [BC_W-1:0] n;
        n = '0;
        for (int i = 0; i < SB; i++) begin
            if (strb[i]) begin
                n = BC_W'(i + 1);
            end
        end
        return n;
    endfunction

    logic                    s_tready_s;
    logic                    s_hs_s;
    logic                    first_r;
    logic [C_USER_WIDTH-1:0] tuser_lat_r;
    logic [C_USER_WIDTH-1:0] tuser_pick_s;
    logic [C_LEN_WIDTH-1:0]  len_acc_r;
    logic [C_LEN_WIDTH:0]    len_sum_s;
    logic [C_LEN_WIDTH-1:0]  len_sat_s;
    logic [C_LEN_WIDTH-1:0]  pkt_len_r;
    logic                    pkt_len_valid_r;

    assign s_axis.tready = s_tready_s;
    assign s_hs_s        = s_axis.tvalid & s_tready_s;
    assign tuser_pick_s  = first_r ? s_axis.tuser : tuser_lat_r;
    assign len_sum_s     = {1'b0, len_acc_r} + (C_LEN_WIDTH + 1)'(beat_bytes(s_axis.tstrb));
    assign len_sat_s     = len_sum_s[C_LEN_WIDTH] ? {C_LEN_WIDTH{1'b1}} : len_sum_s[C_LEN_WIDTH-1:0];
    assign pkt_len       = pkt_len_r;
    assign pkt_len_valid = pkt_len_valid_r;

    // Tracks packet boundaries on the slave side, latches TUSER, and accumulates the byte length.
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            first_r         <= 1'b1;
            tuser_lat_r     <= '0;
            len_acc_r       <= '0;
            pkt_len_r       <= '0;
            pkt_len_valid_r <= 1'b0;
        end else begin
            pkt_len_valid_r <= 1'b0;
            if (s_hs_s) begin
                if (first_r) begin
                    tuser_lat_r <= s_axis.tuser;
                end
                first_r <= s_axis.tlast;
                if (s_axis.tlast) begin
                    pkt_len_r       <= len_sat_s;
                    pkt_len_valid_r <= 1'b1;
                    len_acc_r       <= '0;
                end else begin
                    len_acc_r <= len_sat_s;
                end
            end
        end
    end

    if (M_W >= S_W) begin : g_up
        logic [M_W-1:0]          acc_data_r;
        logic [MB-1:0]           acc_strb_r;
        logic [M_W-1:0]          word_data_s;
        logic [MB-1:0]           word_strb_s;
        logic                    word_done_s;
        logic [CNT_W-1:0]        cnt_r;
        logic [M_W-1:0]          out_data_r;
        logic [MB-1:0]           out_strb_r;
        logic [C_USER_WIDTH-1:0] out_tuser_r;
        logic                    out_valid_r;
        logic                    out_last_r;

        // The accumulator is cleared whenever a word leaves, so lanes above the current one are already zero.
        always_comb begin
            word_data_s = acc_data_r;
            word_strb_s = acc_strb_r;
            word_data_s[cnt_r*S_W +: S_W] = s_axis.tdata;
            word_strb_s[cnt_r*SB +: SB]   = s_axis.tstrb;
            word_done_s = (cnt_r == LAST_LANE) | s_axis.tlast;
        end

        assign s_tready_s    = ~out_valid_r | m_axis.tready;
        assign m_axis.tdata  = out_data_r;
        assign m_axis.tstrb  = out_strb_r;
        assign m_axis.tuser  = out_tuser_r;
        assign m_axis.tvalid = out_valid_r;
        assign m_axis.tlast  = out_last_r;

        // Packs the narrow beats into lanes and hands each finished word to the output register.
        always_ff @(posedge axi_aclk or posedge axi_reset) begin
            if (axi_reset) begin
                acc_data_r  <= '0;
                acc_strb_r  <= '0;
                cnt_r       <= '0;
                out_data_r  <= '0;
                out_strb_r  <= '0;
                out_tuser_r <= '0;
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end else begin
                if (s_hs_s && word_done_s) begin
                    out_data_r  <= word_data_s;
                    out_strb_r  <= word_strb_s;
                    out_tuser_r <= tuser_pick_s;
                    out_last_r  <= s_axis.tlast;
                    out_valid_r <= 1'b1;
                    acc_data_r  <= '0;
                    acc_strb_r  <= '0;
                    cnt_r       <= '0;
                end else begin
                    if (m_axis.tready) begin
                        out_valid_r <= 1'b0;
                    end
                    if (s_hs_s) begin
                        acc_data_r <= word_data_s;
                        acc_strb_r <= word_strb_s;
                        cnt_r      <= cnt_r + 1'b1;
                    end
                end
            end
        end
    end else begin : g_dn
        logic [S_W-1:0]          buf_data_r;
        logic [SB-1:0]           buf_strb_r;
        logic [C_USER_WIDTH-1:0] buf_tuser_r;
        logic                    buf_valid_r;
        logic                    buf_last_r;
        logic [CNT_W-1:0]        cnt_r;
        logic [MB-1:0]           next_strb_s;
        logic                    final_s;

        // A tlast beat ends at the first lane whose successor carries no strobes.
        always_comb begin
            if (cnt_r == LAST_LANE) begin
                next_strb_s = '0;
            end else begin
                next_strb_s = buf_strb_r[(32'(cnt_r) + 32'd1)*MB +: MB];
            end
            final_s = (cnt_r == LAST_LANE) | (buf_last_r & (next_strb_s == '0));
        end

        assign s_tready_s    = ~buf_valid_r | (m_axis.tready & final_s);
        assign m_axis.tdata  = buf_data_r[cnt_r*M_W +: M_W];
        assign m_axis.tstrb  = buf_strb_r[cnt_r*MB +: MB];
        assign m_axis.tuser  = buf_tuser_r;
        assign m_axis.tvalid = buf_valid_r;
        assign m_axis.tlast  = buf_last_r & final_s;

        // A one-entry wide buffer that refills in the same cycle it empties, so the stream has no gaps.
        always_ff @(posedge axi_aclk or posedge axi_reset) begin
            if (axi_reset) begin
                buf_data_r  <= '0;
                buf_strb_r  <= '0;
                buf_tuser_r <= '0;
                buf_valid_r <= 1'b0;
                buf_last_r  <= 1'b0;
                cnt_r       <= '0;
            end else if (s_hs_s) begin
                buf_data_r  <= s_axis.tdata;
                buf_strb_r  <= s_axis.tstrb;
                buf_tuser_r <= tuser_pick_s;
                buf_last_r  <= s_axis.tlast;
                buf_valid_r <= 1'b1;
                cnt_r       <= '0;
            end else if (buf_valid_r && m_axis.tready) begin
                if (final_s) begin
                    buf_valid_r <= 1'b0;
                    cnt_r       <= '0;
                end else begin
                    cnt_r <= cnt_r + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_nf10_axis_width_converter_v2.sv
// Scoreboard bench: one 64->256 upsizer instance and one 256->64 downsizer instance.
// Send tasks queue expected beats and lengths; negedge monitors pop and compare them.
module tb_nf10_axis_width_converter_v2;
    localparam int UW = 128;
    localparam int LW = 16;

    logic axi_aclk = 1'b0;
    logic axi_reset;
    always #5 axi_aclk = ~axi_aclk;

    nf10_axis_width_converter_v2_if #(.DATA_WIDTH(64),  .USER_WIDTH(UW)) up_s ();
    nf10_axis_width_converter_v2_if #(.DATA_WIDTH(256), .USER_WIDTH(UW)) up_m ();
    nf10_axis_width_converter_v2_if #(.DATA_WIDTH(256), .USER_WIDTH(UW)) dn_s ();
    nf10_axis_width_converter_v2_if #(.DATA_WIDTH(64),  .USER_WIDTH(UW)) dn_m ();
    logic [LW-1:0] up_len, dn_len;
    logic          up_len_v, dn_len_v;

    nf10_axis_width_converter_v2 #(.C_M_AXIS_DATA_WIDTH(256), .C_S_AXIS_DATA_WIDTH(64),
        .C_USER_WIDTH(UW), .C_LEN_WIDTH(LW)) u_up (
        .axi_aclk(axi_aclk), .axi_reset(axi_reset), .s_axis(up_s), .m_axis(up_m),
        .pkt_len(up_len), .pkt_len_valid(up_len_v));
    nf10_axis_width_converter_v2 #(.C_M_AXIS_DATA_WIDTH(64), .C_S_AXIS_DATA_WIDTH(256),
        .C_USER_WIDTH(UW), .C_LEN_WIDTH(LW)) u_dn (
        .axi_aclk(axi_aclk), .axi_reset(axi_reset), .s_axis(dn_s), .m_axis(dn_m),
        .pkt_len(dn_len), .pkt_len_valid(dn_len_v));

    typedef struct {
        logic [255:0] data;
        logic [31:0]  strb;
        logic         last;
        logic [127:0] user;
    } beat_t;

    beat_t         up_q[$], dn_q[$];
    logic [LW-1:0] up_lq[$], dn_lq[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event seen where none was required", name);
    endtask

    // master-side ready patterns: 0 always ready, 1 random, 2 never ready
    int up_rmode = 0;
    int dn_rmode = 0;
    initial begin
        up_m.tready = 1'b1;
        dn_m.tready = 1'b1;
        forever begin
            @(posedge axi_aclk);
            #1;
            up_m.tready = (up_rmode == 0) ? 1'b1 : (up_rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            dn_m.tready = (dn_rmode == 0) ? 1'b1 : (dn_rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // reference models
    logic [255:0] um_d = '0;
    logic [31:0]  um_s = '0;
    int           um_cnt = 0;
    int           um_len = 0;
    logic         um_first = 1'b1;
    logic [127:0] um_user = '0;
    int           dm_len = 0;
    logic         dm_first = 1'b1;
    logic [127:0] dm_user = '0;

    task automatic up_send(input logic [63:0] d, input logic [7:0] s, input logic last, input logic [127:0] u);
        int n = 0;
        if (um_first) um_user = u;
        um_first = last;
        um_d[um_cnt*64 +: 64] = d;
        um_s[um_cnt*8 +: 8]   = s;
        um_len += $countones(s);
        if (last || um_cnt == 3) begin
            up_q.push_back('{data: um_d, strb: um_s, last: last, user: um_user});
            um_d = '0;
            um_s = '0;
            um_cnt = 0;
        end else begin
            um_cnt++;
        end
        if (last) begin
            up_lq.push_back(LW'(um_len > 65535 ? 65535 : um_len));
            um_len = 0;
        end
        up_s.tdata = d; up_s.tstrb = s; up_s.tlast = last; up_s.tuser = u; up_s.tvalid = 1'b1;
        @(negedge axi_aclk);
        while (!up_s.tready && n < 1000) begin @(negedge axi_aclk); n++; end
        if (n >= 1000) flag("up_send_timeout");
        @(posedge axi_aclk);
        #1;
        up_s.tvalid = 1'b0;
    endtask

    task automatic dn_send(input logic [255:0] d, input logic [31:0] s, input logic last, input logic [127:0] u);
        int n = 0;
        int nb;
        int lanes;
        if (dm_first) dm_user = u;
        dm_first = last;
        nb = $countones(s);
        dm_len += nb;
        lanes = last ? (nb + 7) / 8 : 4;
        if (lanes == 0) lanes = 1;
        for (int i = 0; i < lanes; i++)
            dn_q.push_back('{data: 256'(d[i*64 +: 64]), strb: 32'(s[i*8 +: 8]),
                             last: last && (i == lanes - 1), user: dm_user});
        if (last) begin
            dn_lq.push_back(LW'(dm_len > 65535 ? 65535 : dm_len));
            dm_len = 0;
        end
        dn_s.tdata = d; dn_s.tstrb = s; dn_s.tlast = last; dn_s.tuser = u; dn_s.tvalid = 1'b1;
        @(negedge axi_aclk);
        while (!dn_s.tready && n < 1000) begin @(negedge axi_aclk); n++; end
        if (n >= 1000) flag("dn_send_timeout");
        @(posedge axi_aclk);
        #1;
        dn_s.tvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((up_q.size() != 0 || dn_q.size() != 0 || up_lq.size() != 0 || dn_lq.size() != 0) && n < 3000) begin
            @(negedge axi_aclk);
            n++;
        end
        if (n >= 3000) flag("drain_timeout");
        repeat (3) @(posedge axi_aclk);
        #1;
    endtask

    // monitors
    beat_t         ue, de;
    logic          up_stall = 1'b0, dn_stall = 1'b0;
    logic [255:0]  up_hold_d;
    logic [160:0]  up_hold_c;
    logic [63:0]   dn_hold_d;
    logic [136:0]  dn_hold_c;
    logic [31:0]   up_seen_strb = '0;
    logic [127:0]  up_seen_user = '0;
    logic [LW-1:0] up_seen_len = '0, dn_seen_len = '0;
    logic [7:0]    dn_seen_strb = '0;
    int            dn_beats = 0, dn_run = 0, dn_run_max = 0;

    always @(negedge axi_aclk) begin
        if (axi_reset) begin
            up_stall = 1'b0;
        end else begin
            if (up_stall) begin
                chk("up_hold_data", up_m.tdata, up_hold_d);
                chk("up_hold_ctl", 256'({up_m.tuser, up_m.tstrb, up_m.tlast}), 256'(up_hold_c));
            end
            up_stall  = up_m.tvalid && !up_m.tready;
            up_hold_d = up_m.tdata;
            up_hold_c = {up_m.tuser, up_m.tstrb, up_m.tlast};
            if (up_m.tvalid && up_m.tready) begin
                if (up_q.size() == 0) begin
                    flag("up_extra_beat");
                end else begin
                    ue = up_q.pop_front();
                    chk("up_data", up_m.tdata, ue.data);
                    chk("up_strb", 256'(up_m.tstrb), 256'(ue.strb));
                    chk("up_last", 256'(up_m.tlast), 256'(ue.last));
                    chk("up_user", 256'(up_m.tuser), 256'(ue.user));
                    up_seen_strb = up_m.tstrb;
                    up_seen_user = up_m.tuser;
                end
            end
            if (up_len_v) begin
                if (up_lq.size() == 0) flag("up_extra_len");
                else chk("up_pkt_len", 256'(up_len), 256'(up_lq.pop_front()));
                up_seen_len = up_len;
            end
        end
    end

    always @(negedge axi_aclk) begin
        if (axi_reset) begin
            dn_stall = 1'b0;
            dn_run   = 0;
        end else begin
            if (dn_stall) begin
                chk("dn_hold_data", 256'(dn_m.tdata), 256'(dn_hold_d));
                chk("dn_hold_ctl", 256'({dn_m.tuser, dn_m.tstrb, dn_m.tlast}), 256'(dn_hold_c));
            end
            dn_stall  = dn_m.tvalid && !dn_m.tready;
            dn_hold_d = dn_m.tdata;
            dn_hold_c = {dn_m.tuser, dn_m.tstrb, dn_m.tlast};
            dn_run    = dn_m.tvalid ? dn_run + 1 : 0;
            if (dn_run > dn_run_max) dn_run_max = dn_run;
            if (dn_m.tvalid && dn_m.tready) begin
                if (dn_q.size() == 0) begin
                    flag("dn_extra_beat");
                end else begin
                    de = dn_q.pop_front();
                    chk("dn_data", 256'(dn_m.tdata), de.data);
                    chk("dn_strb", 256'(dn_m.tstrb), 256'(de.strb));
                    chk("dn_last", 256'(dn_m.tlast), 256'(de.last));
                    chk("dn_user", 256'(dn_m.tuser), 256'(de.user));
                    dn_seen_strb = dn_m.tstrb;
                    dn_beats++;
                end
            end
            if (dn_len_v) begin
                if (dn_lq.size() == 0) flag("dn_extra_len");
                else chk("dn_pkt_len", 256'(dn_len), 256'(dn_lq.pop_front()));
                dn_seen_len = dn_len;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [127:0] u;
    logic [255:0] wd;
    int           k;

    initial begin
        axi_reset = 1'b1;
        up_s.tvalid = 1'b0; up_s.tdata = '0; up_s.tstrb = '0; up_s.tlast = 1'b0; up_s.tuser = '0;
        dn_s.tvalid = 1'b0; dn_s.tdata = '0; dn_s.tstrb = '0; dn_s.tlast = 1'b0; dn_s.tuser = '0;
        repeat (2) @(posedge axi_aclk);
        #1;
        chk("rst_up_tvalid", 256'(up_m.tvalid), 256'd0);
        chk("rst_up_tready", 256'(up_s.tready), 256'd1);
        chk("rst_up_len",    256'({up_len, up_len_v}), 256'd0);
        chk("rst_dn_tvalid", 256'(dn_m.tvalid), 256'd0);
        chk("rst_dn_tready", 256'(dn_s.tready), 256'd1);
        chk("rst_dn_out",    256'({dn_m.tdata, dn_m.tstrb, dn_m.tlast}), 256'd0);
        axi_reset = 1'b0;
        @(posedge axi_aclk);
        #1;

        // 64->256: four full beats make one full word
        for (int i = 0; i < 4; i++) up_send(64'hC0DE_0000_0000_0000 | 64'(i), 8'hFF, i == 3, 128'hA1);
        wait_idle();
        chk("t1_strb", 256'(up_seen_strb), 256'hFFFF_FFFF);
        chk("t1_len",  256'(up_seen_len), 256'd32);

        // 64->256: three beats, the last one half-filled
        up_send(64'h1111_2222_3333_4444, 8'hFF, 1'b0, 128'hA2);
        up_send(64'h5555_6666_7777_8888, 8'hFF, 1'b0, 128'hBAD);
        up_send(64'h0000_0000_9999_AAAA, 8'h0F, 1'b1, 128'hBAD);
        wait_idle();
        chk("t2_strb", 256'(up_seen_strb), 256'h000F_FFFF);
        chk("t2_len",  256'(up_seen_len), 256'd20);
        chk("t2_user", 256'(up_seen_user), 256'hA2);

        // 64->256: back-to-back single-beat packets
        up_send(64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b1, 128'hC1);
        up_send(64'hDEAD_BEEF_0000_0002, 8'h03, 1'b1, 128'hC2);
        wait_idle();
        chk("t3_user", 256'(up_seen_user), 256'hC2);

        // 256->64: twelve bytes leave as two master beats
        dn_beats = 0;
        dn_send({64'h0, 64'h0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210}, 32'h0000_0FFF, 1'b1, 128'hD1);
        wait_idle();
        chk("t4_beats", 256'(dn_beats), 256'd2);
        chk("t4_strb",  256'(dn_seen_strb), 256'h0F);
        chk("t4_len",   256'(dn_seen_len), 256'd12);

        // 256->64: two packets back to back, eight master beats with no gap
        dn_run_max = 0;
        dn_send({4{64'hAAAA_0000_1111_2222}}, 32'hFFFF_FFFF, 1'b1, 128'hAAAA);
        dn_send({4{64'hBBBB_0000_3333_4444}}, 32'hFFFF_FFFF, 1'b1, 128'hBBBB);
        wait_idle();
        chk("t5_run", 256'(dn_run_max), 256'd8);

        // 256->64: tlast with no strobes produces one empty master beat
        dn_beats = 0;
        dn_send(256'h5A, 32'h0, 1'b1, 128'hE1);
        wait_idle();
        chk("t6_beats", 256'(dn_beats), 256'd1);
        chk("t6_len",   256'(dn_seen_len), 256'd0);

        // random master stalls on both converters
        up_rmode = 1;
        dn_rmode = 1;
        for (int p = 0; p < 3; p++) begin
            u = {$urandom, $urandom, $urandom, $urandom};
            for (int b = 0; b < 5; b++) begin
                k = $urandom_range(1, 8);
                up_send({$urandom, $urandom}, (b == 4) ? 8'((16'd1 << k) - 16'd1) : 8'hFF, b == 4, u);
            end
            u = {$urandom, $urandom, $urandom, $urandom};
            for (int b = 0; b < 2; b++) begin
                for (int w = 0; w < 8; w++) wd[w*32 +: 32] = $urandom;
                k = $urandom_range(1, 32);
                dn_send(wd, (b == 1) ? 32'((64'd1 << k) - 64'd1) : 32'hFFFF_FFFF, b == 1, u);
            end
        end
        wait_idle();
        up_rmode = 0;
        dn_rmode = 0;

        // reset mid-packet on the upsizer and with a stalled beat in the downsizer
        up_send(64'h0BAD_0000_0000_0001, 8'hFF, 1'b0, 128'hF0);
        up_send(64'h0BAD_0000_0000_0002, 8'hFF, 1'b0, 128'hF0);
        dn_rmode = 2;
        @(posedge axi_aclk);
        #2;
        dn_send({4{64'h0BAD_0BAD_0BAD_0BAD}}, 32'hFFFF_FFFF, 1'b1, 128'hF1);
        repeat (2) @(posedge axi_aclk);
        #3;
        axi_reset = 1'b1;
        #1;
        chk("mid_rst_dn_tvalid", 256'(dn_m.tvalid), 256'd0);
        chk("mid_rst_dn_tready", 256'(dn_s.tready), 256'd1);
        chk("mid_rst_dn_out",    256'({dn_m.tdata, dn_m.tstrb, dn_m.tuser, dn_len}), 256'd0);
        chk("mid_rst_up_out",    256'({up_m.tvalid, up_m.tstrb, up_m.tuser, up_len}), 256'd0);
        chk("mid_rst_up_data",   up_m.tdata, 256'd0);
        chk("mid_rst_up_tready", 256'(up_s.tready), 256'd1);
        dn_q.delete();
        dn_lq.delete();
        up_q.delete();
        up_lq.delete();
        um_d = '0; um_s = '0; um_cnt = 0; um_len = 0; um_first = 1'b1;
        dm_len = 0; dm_first = 1'b1;
        dn_rmode = 0;
        @(posedge axi_aclk);
        #1;
        axi_reset = 1'b0;
        up_send(64'h600D_0000_0000_0001, 8'hFF, 1'b0, 128'h77);
        up_send(64'h600D_0000_0000_0002, 8'hFF, 1'b1, 128'h88);
        dn_send({64'h0, 64'h0, 64'h600D_0000_0000_0004, 64'h600D_0000_0000_0003}, 32'h0000_FFFF, 1'b1, 128'h99);
        wait_idle();
        chk("post_rst_up_user", 256'(up_seen_user), 256'h77);
        chk("post_rst_up_strb", 256'(up_seen_strb), 256'h0000_FFFF);
        chk("post_rst_up_len",  256'(up_seen_len), 256'd16);
        chk("post_rst_dn_len",  256'(dn_seen_len), 256'd16);

        chk("end_up_q", 256'(up_q.size() + up_lq.size()), 256'd0);
        chk("end_dn_q", 256'(dn_q.size() + dn_lq.size()), 256'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
